// File: rtl/seg7_scan_decoder.sv
// Loopback monitor for a multiplexed active-low 7-segment bus: synchronizes the
// pins, waits for a stable window, then decodes the lit digit back to BCD.
module seg7_scan_decoder #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned STABLE_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     an_in,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   digits_out,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  bad_pattern,
   output logic                  frame_done
);

   localparam int unsigned W = DIGITS + 7;

   logic [W-1:0]        sync1;
   logic [W-1:0]        smp;
   logic [W-1:0]        prev;
   logic [7:0]          cnt;
   logic                capture;
   logic                cap_q;
   logic [W-1:0]        cap_data;

   logic [DIGITS-1:0]   an_low;
   logic [6:0]          cap_seg;
   logic                multi_low;
   logic [DIGITS-1:0]   seen;
   logic [DIGITS-1:0]   seen_nxt;
   logic [4*DIGITS-1:0] digits_nxt;
   logic [DIGITS-1:0]   valid_nxt;
   logic                bad_nxt;
   logic                frame_nxt;

   // Returns {legal, blank, bcd[3:0]}
   function automatic logic [5:0] decode(input logic [6:0] s);
      logic [5:0] r;
      case (s)
         7'b1000000: r = {2'b10, 4'd0};
         7'b1111001: r = {2'b10, 4'd1};
         7'b0100100: r = {2'b10, 4'd2};
         7'b0110000: r = {2'b10, 4'd3};
         7'b0011001: r = {2'b10, 4'd4};
         7'b0010010: r = {2'b10, 4'd5};
         7'b0000010: r = {2'b10, 4'd6};
         7'b1111000: r = {2'b10, 4'd7};
         7'b0000000: r = {2'b10, 4'd8};
         7'b0010000: r = {2'b10, 4'd9};
         7'b1111111: r = {2'b01, 4'd0};
         default:    r = {2'b00, 4'd0};
      endcase
      return r;
   endfunction

   // Saturated count after reset: a held pattern never re-fires until the input changes.
   assign capture = (smp == prev) && (cnt == 8'(STABLE_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= '1;
         smp      <= '1;
         prev     <= '1;
         cnt      <= 8'(STABLE_CYC);
         cap_q    <= 1'b0;
         cap_data <= '1;
      end else begin
         sync1 <= {an_in, seg_in};
         smp   <= sync1;
         prev  <= smp;
         if (smp != prev)
            cnt <= '0;
         else if (cnt != 8'(STABLE_CYC))
            cnt <= cnt + 8'd1;
         cap_q <= capture;
         if (capture)
            cap_data <= smp;
      end
   end

   assign an_low    = ~cap_data[W-1:7];
   assign cap_seg   = cap_data[6:0];
   assign multi_low = |(an_low & (an_low - DIGITS'(1)));

   always_comb begin
      logic [5:0]        dec;
      logic [DIGITS-1:0] seen_or;
      digits_nxt = digits_out;
      valid_nxt  = digit_valid;
      bad_nxt    = bad_pattern;
      seen_nxt   = seen;
      frame_nxt  = 1'b0;
      dec        = decode(cap_seg);
      seen_or    = seen | an_low;
      if (clear) begin
         valid_nxt = '0;
         seen_nxt  = '0;
         bad_nxt   = 1'b0;
      end else if (cap_q && (an_low != '0)) begin
         if (multi_low) begin
            bad_nxt = 1'b1;
         end else begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (an_low[i]) begin
                  if (dec[5]) begin
                     digits_nxt[4*i +: 4] = dec[3:0];
                     valid_nxt[i]         = 1'b1;
                  end else begin
                     valid_nxt[i] = 1'b0;
                     if (!dec[4])
                        bad_nxt = 1'b1;
                  end
               end
            end
            if (&seen_or) begin
               frame_nxt = 1'b1;
               seen_nxt  = '0;
            end else begin
               seen_nxt = seen_or;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_out  <= '0;
         digit_valid <= '0;
         bad_pattern <= 1'b0;
         frame_done  <= 1'b0;
         seen        <= '0;
      end else begin
         digits_out  <= digits_nxt;
         digit_valid <= valid_nxt;
         bad_pattern <= bad_nxt;
         frame_done  <= frame_nxt;
         seen        <= seen_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: latency, glitch rejection, full scan,
// error flags and the clear/capture collision.
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic        clear;
   logic [15:0] digits_out;
   logic [3:0]  digit_valid;
   logic        bad_pattern;
   logic        frame_done;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned frame_cnt = 0;
   logic [6:0]  code [10];

   seg7_scan_decoder #(.DIGITS(4), .STABLE_CYC(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .an_in       (an_in),
      .clear       (clear),
      .digits_out  (digits_out),
      .digit_valid (digit_valid),
      .bad_pattern (bad_pattern),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (frame_done) frame_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive pins just after an edge, then wait n edges and settle
   task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_in  = an;
      seg_in = seg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      code[0] = 7'b1000000; code[1] = 7'b1111001; code[2] = 7'b0100100;
      code[3] = 7'b0110000; code[4] = 7'b0011001; code[5] = 7'b0010010;
      code[6] = 7'b0000010; code[7] = 7'b1111000; code[8] = 7'b0000000;
      code[9] = 7'b0010000;

      rst_n = 1'b0; clear = 1'b0; an_in = 4'b1111; seg_in = 7'b1111111;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset mid-window, then held display-off after release
      hold(4'b1110, code[3], 10);
      rst_n = 1'b0;
      hold(4'b1111, 7'b1111111, 3);
      check("rst_digits", 32'(digits_out), 32'h0);
      check("rst_valid", 32'(digit_valid), 32'h0);
      rst_n = 1'b1;
      hold(4'b1111, 7'b1111111, 40);
      check("post_rst_digits", 32'(digits_out), 32'h0);
      check("post_rst_valid", 32'(digit_valid), 32'h0);
      check("post_rst_bad", 32'(bad_pattern), 32'h0);
      check("post_rst_frames", frame_cnt, 32'd0);

      // Single digit: output must appear on edge 19, not before
      hold(4'b1110, code[3], 19);
      check("lat_early_valid", 32'(digit_valid), 32'h0);
      hold(4'b1110, code[3], 1);
      check("single_digits", 32'(digits_out), 32'h0003);
      check("single_valid", 32'(digit_valid), 32'b0001);
      check("single_frame", 32'(frame_done), 32'h0);
      hold(4'b1111, 7'b1111111, 30);

      // 10-cycle glitch on position 1
      hold(4'b1101, code[5], 10);
      hold(4'b1111, 7'b1111111, 30);
      check("glitch_digits", 32'(digits_out), 32'h0003);
      check("glitch_valid", 32'(digit_valid), 32'b0001);

      // Full scan 1,2,3,4 on positions 0..3
      pulse_clear();
      frame_cnt = 0;
      for (int p = 0; p < 4; p++) begin
         hold(~(4'b0001 << p), code[p+1], 20);
         check($sformatf("scan_frame_p%0d", p), 32'(frame_done), (p == 3) ? 32'h1 : 32'h0);
      end
      hold(4'b1111, 7'b1111111, 1);
      check("scan_frame_after", 32'(frame_done), 32'h0);
      hold(4'b1111, 7'b1111111, 30);
      check("scan_digits", 32'(digits_out), 32'h4321);
      check("scan_valid", 32'(digit_valid), 32'b1111);
      check("scan_frame_count", frame_cnt, 32'd1);

      // Blank on position 1: invalidates, not an error
      hold(4'b1101, 7'b1111111, 20);
      check("blank_valid", 32'(digit_valid), 32'b1101);
      check("blank_bad", 32'(bad_pattern), 32'h0);
      check("blank_digits", 32'(digits_out), 32'h4321);
      hold(4'b1111, 7'b1111111, 30);

      // Illegal code on position 2
      hold(4'b1011, 7'b0101010, 20);
      check("illegal_bad", 32'(bad_pattern), 32'h1);
      check("illegal_valid", 32'(digit_valid), 32'b1001);
      check("illegal_digits", 32'(digits_out), 32'h4321);
      hold(4'b1111, 7'b1111111, 30);
      check("illegal_sticky", 32'(bad_pattern), 32'h1);
      pulse_clear();
      check("clear_bad", 32'(bad_pattern), 32'h0);
      check("clear_valid", 32'(digit_valid), 32'h0);
      check("clear_digits", 32'(digits_out), 32'h4321);

      // Two anodes low with a legal code
      hold(4'b1100, code[7], 20);
      check("multi_bad", 32'(bad_pattern), 32'h1);
      check("multi_digits", 32'(digits_out), 32'h4321);
      check("multi_valid", 32'(digit_valid), 32'h0);
      hold(4'b1111, 7'b1111111, 30);
      check("multi_sticky", 32'(bad_pattern), 32'h1);
      pulse_clear();
      check("multi_clear_bad", 32'(bad_pattern), 32'h0);

      // Set up a valid digit, then collide clear with a capture
      hold(4'b1101, code[5], 20);
      check("pre_coll_digits", 32'(digits_out), 32'h4351);
      check("pre_coll_valid", 32'(digit_valid), 32'b0010);
      hold(4'b1111, 7'b1111111, 30);
      hold(4'b1110, code[9], 19);
      pulse_clear();
      check("coll_valid", 32'(digit_valid), 32'h0);
      check("coll_bad", 32'(bad_pattern), 32'h0);
      check("coll_digits", 32'(digits_out), 32'h4351);
      hold(4'b1110, code[9], 40);
      check("coll_hold_digits", 32'(digits_out), 32'h4351);
      check("coll_hold_valid", 32'(digit_valid), 32'h0);
      check("final_frame_count", frame_cnt, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Recovers BCD digit values from a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and presents them as registered BCD words with per-digit valid flags. It is the inverse of the BCD-to-7-segment encoding used by the alarm clock display path. It sits on the display pins as a loopback/self-check monitor, so the clock core or a test bench can confirm what the scanned display is actually showing. Inputs are treated as asynchronous; all outputs are registered in the `clk` domain.

## Interface
- `DIGITS`, default 4: number of multiplexed digit positions.
- `STABLE_CYC`, default 16: consecutive identical synchronized samples required before capture; legal range 2..255.

- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `seg_in` input 7: segment lines, active-low; bit 6 = g … bit 0 = a.
- `an_in` input DIGITS: anode enables, active-low; exactly one low selects a digit.
- `clear` input 1: synchronous clear of valids, seen-mask and error flag.
- `digits_out` output 4*DIGITS: BCD per digit; digit i at bits [4i+3:4i].
- `digit_valid` output DIGITS: digit i holds a legal decoded value.
- `bad_pattern` output 1: sticky error flag.
- `frame_done` output 1: one-cycle pulse after every position has been captured.

## Operation
- **Input synchronizer.** `{an_in, seg_in}` pass through a 2-flop synchronizer. Stage-2 output is `smp`.
- **Stability tracking.**
  - `prev` holds `smp` delayed one cycle.
  - `cnt` resets to 0 when `smp != prev`.
  - Otherwise `cnt` increments and saturates at STABLE_CYC.
- **Capture event.** Fires for exactly one cycle when `smp == prev` and `cnt == STABLE_CYC-1`. A held pattern is captured only once; a new capture requires an input change followed by a new stable window.
- **Anode check at capture:**
  - All anodes high (display off): no action.
  - More than one anode low: set `bad_pattern`; no digit update.
  - Exactly one low, at position i: decode `seg`, then set `seen[i]`.
- **Decode (seg to BCD).**
  - Legal codes: 1000000 = 0, 1111001 = 1, 0100100 = 2, 0110000 = 3, 0011001 = 4, 0010010 = 5, 0000010 = 6, 1111000 = 7, 0000000 = 8, 0010000 = 9.
  - Legal code: `digits_out[i]` is loaded with the value and `digit_valid[i]` is set to 1.
  - 1111111 (blank): `digit_valid[i]` is set to 0 and `digits_out[i]` is unchanged. Not an error.
  - Any other code: `digit_valid[i]` is set to 0, `digits_out[i]` is unchanged, and `bad_pattern` is set.
- **Frame tracking.**
  - `seen` is an internal DIGITS-bit mask.
  - When a capture makes `seen` all-ones, `frame_done` pulses in the same update cycle and `seen` reloads to 0.
  - A digit captured twice within a frame is not an error.
- **`clear`.**
  - Effect: `digit_valid`, `seen` and `bad_pattern` go to 0; `digits_out` is retained.
  - `clear` has priority over a simultaneous capture, which is discarded.
  - The `cnt` saturation is unaffected, so a held pattern is not recaptured.
- **`bad_pattern`.** Sticky until `clear` or reset.

## Timing
- **Reset values:**
  - `digits_out` = 0, `digit_valid` = 0, `bad_pattern` = 0, `frame_done` = 0.
  - Synchronizers and `prev` = all-ones (blank, display off).
  - `cnt` = STABLE_CYC, i.e. saturated, so there is no spurious capture after reset.
- **Latency.** Pins change before edge 0 and then hold. Outputs update on edge STABLE_CYC+3, which is also the edge where `frame_done` asserts if that capture completes a frame.
- **Glitch rejection.** Any change lasting fewer than STABLE_CYC synchronized samples produces no capture.
- **Reset mid-window.** An in-progress window is abandoned.
- **`frame_done`.** High for exactly one cycle, never on consecutive cycles for DIGITS > 1.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-capture, then release → all outputs 0; a held `an_in` = 1111 / `seg_in` = 1111111 produces no capture.
- **Single digit:** STABLE_CYC = 16; drive `an_in` = 1110, `seg_in` = 0110000 → on edge 19, `digits_out[3:0]` = 3, `digit_valid` = 0001, no `frame_done`.
- **Glitch rejection:** a 10-cycle pulse of `seg_in` = 0010010 on `an_in` = 1101, then return to display-off → `digits_out` and `digit_valid` unchanged.
- **Full scan:** 20 cycles per digit showing 1, 2, 3, 4 on positions 0..3:
  - `digits_out` = 0x4321, `digit_valid` = 1111.
  - `frame_done` is high for exactly one cycle, on the position-3 capture.
- **Errors:**
  - `seg_in` = 0101010 on position 2 → `bad_pattern` = 1, `digit_valid[2]` = 0.
  - `an_in` = 1100 with a legal code → `bad_pattern` = 1, digits unchanged.
  - Both cases: `bad_pattern` stays 1 until `clear`.
- **Clear collision:** pulse `clear` on the exact capture edge → `digit_valid` = 0, `bad_pattern` = 0, no update from that capture; holding the input produces no later capture.
